// File: rtl/pc_sequencer.sv
// Program-counter sequencer: drives reset, absolute jumps and jump targets for an
// external program counter, with a return-address stack for call/return.
module pc_sequencer #(
  parameter int D     = 12,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [D-1:0]                 prog_ctr,
  input  logic                         stall,
  input  logic                         br_taken,
  input  logic [D-1:0]                 br_target,
  input  logic                         call_en,
  input  logic [D-1:0]                 call_target,
  input  logic                         ret_en,
  input  logic                         halt_req,
  output logic                         pc_reset,
  output logic                         absjump_en,
  output logic [D-1:0]                 target,
  output logic                         running,
  output logic                         done,
  output logic                         fault,
  output logic [$clog2(DEPTH+1)-1:0]   ras_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    FAULT  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   ras_count_q, ras_count_d;
  logic [D-1:0]    stack_q [DEPTH];
  logic [D-1:0]    stack_d [DEPTH];
  logic [AW-1:0]   push_idx;
  logic [AW-1:0]   top_idx;
  logic [D-1:0]    ret_addr;

  assign push_idx = AW'(ras_count_q);
  assign top_idx  = AW'(ras_count_q - CW'(1));
  // Return address wraps naturally at the top of the address space.
  assign ret_addr = prog_ctr + {{(D-1){1'b0}}, 1'b1};

  // State, occupancy and stack registers; reset discards all stack contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ras_count_q <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= {D{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      ras_count_q <= ras_count_d;
      stack_q     <= stack_d;
    end
  end

  // Next-state and same-cycle program-counter control, one action per cycle.
  always_comb begin
    state_d     = state_q;
    ras_count_d = ras_count_q;
    stack_d     = stack_q;
    pc_reset    = 1'b0;
    absjump_en  = 1'b0;
    target      = {D{1'b0}};
    if (reset) begin
      pc_reset = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          pc_reset = 1'b1;
          if (start) begin
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          if (halt_req) begin
            absjump_en = 1'b1;
            target     = prog_ctr;
            state_d    = HALTED;
          end else if (ret_en) begin
            absjump_en = 1'b1;
            if (ras_count_q != {CW{1'b0}}) begin
              target      = stack_q[top_idx];
              ras_count_d = ras_count_q - CW'(1);
            end else begin
              target  = prog_ctr;
              state_d = FAULT;
            end
          end else if (call_en) begin
            absjump_en = 1'b1;
            if (ras_count_q < CW'(DEPTH)) begin
              target            = call_target;
              stack_d[push_idx] = ret_addr;
              ras_count_d       = ras_count_q + CW'(1);
            end else begin
              target  = prog_ctr;
              state_d = FAULT;
            end
          end else if (br_taken) begin
            absjump_en = 1'b1;
            target     = br_target;
          end else if (stall) begin
            absjump_en = 1'b1;
            target     = prog_ctr;
          end else begin
            absjump_en = 1'b0;
          end
        end
        HALTED, FAULT: begin
          absjump_en = 1'b1;
          target     = prog_ctr;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign running   = (state_q == RUN);
  assign done      = (state_q == HALTED);
  assign fault     = (state_q == FAULT);
  assign ras_count = ras_count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a behavioural program counter closing the loop.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [11:0] br_target = 12'h000;
  logic        call_en = 1'b0;
  logic [11:0] call_target = 12'h000;
  logic        ret_en = 1'b0;
  logic        halt_req = 1'b0;
  logic        pc_reset, absjump_en, running, done, fault;
  logic [11:0] target;
  logic [2:0]  ras_count;
  logic [11:0] pc = 12'h000;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(.D(12), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .prog_ctr(pc), .stall(stall),
    .br_taken(br_taken), .br_target(br_target), .call_en(call_en),
    .call_target(call_target), .ret_en(ret_en), .halt_req(halt_req),
    .pc_reset(pc_reset), .absjump_en(absjump_en), .target(target),
    .running(running), .done(done), .fault(fault), .ras_count(ras_count)
  );

  always #5 clk = ~clk;

  // Program counter the sequencer steers.
  always @(posedge clk) begin
    if (pc_reset) pc <= 12'h000;
    else if (absjump_en) pc <= target;
    else pc <= pc + 12'h001;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    start = 1'b0; stall = 1'b0; br_taken = 1'b0; call_en = 1'b0;
    ret_en = 1'b0; halt_req = 1'b0;
  endtask

  task automatic do_call(input logic [11:0] dest);
    clear_reqs();
    call_en = 1'b1; call_target = dest;
    tick();
    call_en = 1'b0;
  endtask

  task automatic do_branch(input logic [11:0] dest);
    clear_reqs();
    br_taken = 1'b1; br_target = dest;
    tick();
    br_taken = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    tick(); tick();
    reset = 1'b0;
    #1;
    check_eq("rst_pc_reset", pc_reset, 1);
    check_eq("rst_absjump", absjump_en, 0);
    check_eq("rst_ras", ras_count, 0);
    check_eq("rst_flags", {running, done, fault}, 0);
    check_eq("rst_pc", pc, 0);

    // Start and sequential run: PC 0,0,1,2,3
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    check_eq("run_flag", running, 1);
    check_eq("run_pc0", pc, 12'h000);
    check_eq("run_absjump", absjump_en, 0);
    check_eq("run_pc_reset", pc_reset, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_eq("run_seq_pc", pc, i);
    end

    // Call / return
    do_branch(12'h010);
    check_eq("br_pc", pc, 12'h010);
    call_en = 1'b1; call_target = 12'h200;
    #1;
    check_eq("call_tgt", target, 12'h200);
    tick();
    call_en = 1'b0;
    check_eq("call_pc", pc, 12'h200);
    check_eq("call_ras", ras_count, 1);
    tick();
    check_eq("seq_after_call", pc, 12'h201);
    ret_en = 1'b1;
    #1;
    check_eq("ret_tgt", target, 12'h011);
    tick();
    ret_en = 1'b0;
    check_eq("ret_pc", pc, 12'h011);
    check_eq("ret_ras", ras_count, 0);

    // Stall hold, branch beats stall
    br_taken = 1'b1; br_target = 12'h005; stall = 1'b1;
    tick();
    br_taken = 1'b0;
    check_eq("br_over_stall", pc, 12'h005);
    #1;
    check_eq("stall_absjump", absjump_en, 1);
    check_eq("stall_tgt", target, 12'h005);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_pc", pc, 12'h005);
    end
    stall = 1'b0; br_taken = 1'b1; br_target = 12'h0A0;
    tick();
    br_taken = 1'b0;
    check_eq("br_after_stall", pc, 12'h0A0);

    // Wrap of return address; call beats branch
    do_branch(12'hFFF);
    call_en = 1'b1; call_target = 12'h100; br_taken = 1'b1; br_target = 12'h777;
    tick();
    clear_reqs();
    check_eq("call_over_br", pc, 12'h100);
    ret_en = 1'b1;
    tick();
    ret_en = 1'b0;
    check_eq("wrap_ret_pc", pc, 12'h000);

    // LIFO order
    do_call(12'h300);
    do_call(12'h400);
    check_eq("lifo_ras2", ras_count, 2);
    ret_en = 1'b1; call_en = 1'b1; call_target = 12'h555;
    tick();
    clear_reqs();
    check_eq("lifo_ret_pc", pc, 12'h301);
    check_eq("lifo_ras1", ras_count, 1);
    do_call(12'h400);
    check_eq("lifo_ras2b", ras_count, 2);

    // Halt beats return and branch
    halt_req = 1'b1; ret_en = 1'b1; br_taken = 1'b1; br_target = 12'h0BB;
    #1;
    check_eq("halt_tgt", target, 12'h400);
    tick();
    clear_reqs();
    check_eq("halt_done", {running, done, fault}, 3'b010);
    check_eq("halt_ras", ras_count, 2);
    check_eq("halt_pc", pc, 12'h400);
    start = 1'b1; call_en = 1'b1; ret_en = 1'b1;
    tick();
    clear_reqs();
    check_eq("halt_frozen_pc", pc, 12'h400);
    check_eq("halt_frozen_ras", ras_count, 2);
    check_eq("halt_ignores_start", done, 1);

    // Reset from HALTED
    reset = 1'b1;
    #1;
    check_eq("rst_ovr_pc_reset", pc_reset, 1);
    check_eq("rst_ovr_absjump", absjump_en, 0);
    tick();
    reset = 1'b0;
    #1;
    check_eq("rst2_ras", ras_count, 0);
    check_eq("rst2_flags", {running, done, fault}, 0);
    check_eq("rst2_pc_reset", pc_reset, 1);
    check_eq("rst2_pc", pc, 12'h000);

    // Underflow fault
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    ret_en = 1'b1;
    #1;
    check_eq("uf_tgt", target, 12'h001);
    tick();
    ret_en = 1'b0;
    check_eq("uf_flags", {running, done, fault}, 3'b001);
    check_eq("uf_pc", pc, 12'h001);
    br_taken = 1'b1; br_target = 12'h0AA;
    tick();
    clear_reqs();
    check_eq("uf_frozen_pc", pc, 12'h001);
    check_eq("uf_still_fault", fault, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Overflow after four nested calls
    start = 1'b1;
    tick();
    start = 1'b0;
    do_call(12'h100);
    do_call(12'h200);
    do_call(12'h300);
    do_call(12'h400);
    check_eq("of_ras4", ras_count, 4);
    do_call(12'h500);
    check_eq("of_flags", {running, done, fault}, 3'b001);
    check_eq("of_pc", pc, 12'h400);
    check_eq("of_ras", ras_count, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter D, default 12, program-counter width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, return-address stack entries (≥2).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begin execution from IDLE.
REQ-006 prog_ctr  input  D  current PC value from the program counter.
REQ-007 stall  input  1  hold PC this cycle.
REQ-008 br_taken  input  1  resolved taken branch.
REQ-009 br_target  input  D  absolute branch destination.
REQ-010 call_en  input  1  subroutine call.
REQ-011 call_target  input  D  absolute call destination.
REQ-012 ret_en  input  1  subroutine return.
REQ-013 halt_req  input  1  stop execution.
REQ-014 pc_reset  output  1  drives program counter reset.
REQ-015 absjump_en  output  1  drives program counter absolute-jump enable.
REQ-016 target  output  D  drives program counter jump target.
REQ-017 running  output  1  high in RUN.
REQ-018 done  output  1  high in HALTED.
REQ-019 fault  output  1  high in FAULT.
REQ-020 ras_count  output  $clog2(DEPTH+1)  current stack occupancy.

Function
REQ-021 SHALL implement FSM states IDLE, RUN, HALTED, FAULT; state, stack and ras_count registered; pc_reset, absjump_en, target combinational from state and inputs (same-cycle), so a redirect lands on prog_ctr at the next edge.
REQ-022 IDLE: pc_reset=1, absjump_en=0, target=0; start=1 -> RUN next edge (PC leaves 0 on the following edge).
REQ-023 RUN, pc_reset=0; exactly one action per cycle, strict priority halt_req > ret_en > call_en > br_taken > stall > sequential; lower-priority requests in that cycle are ignored, not queued.
REQ-024 halt_req: absjump_en=1, target=prog_ctr; -> HALTED.
REQ-025 ret_en with ras_count>0: absjump_en=1, target=top entry; pop; ras_count-1.
REQ-026 ret_en with ras_count=0 (underflow): absjump_en=1, target=prog_ctr; -> FAULT; stack unchanged.
REQ-027 call_en with ras_count<DEPTH: absjump_en=1, target=call_target; push (prog_ctr+1) mod 2^D; ras_count+1.
REQ-028 call_en with ras_count=DEPTH (overflow): absjump_en=1, target=prog_ctr; -> FAULT; stack unchanged.
REQ-029 br_taken: absjump_en=1, target=br_target.
REQ-030 stall: absjump_en=1, target=prog_ctr (PC holds).
REQ-031 no request: absjump_en=0, target=0 (PC increments).
REQ-032 return address at prog_ctr=2^D-1 SHALL wrap to 0.
REQ-033 HALTED and FAULT: absjump_en=1, target=prog_ctr (PC frozen); all inputs except reset ignored; exit only via reset.
REQ-034 start SHALL be ignored outside IDLE.
REQ-035 stack is LIFO; entries beyond ras_count are don't-care.

Reset
REQ-036 reset=1 at any edge, any state, SHALL force IDLE, ras_count=0, running=done=fault=0, pc_reset=1, overriding all other inputs that cycle.
REQ-037 reset mid-call-sequence SHALL discard all stack contents.

Verification
REQ-038 reset, then start; no requests 5 cycles -> PC 0,0,1,2,3; absjump_en=0; running=1.
REQ-039 prog_ctr=0x010, call_en, call_target=0x200 -> next PC 0x200, ras_count=1; later ret_en -> next PC 0x011, ras_count=0.
REQ-040 DEPTH=4: five nested calls -> fifth cycle: state FAULT, fault=1, PC frozen at fifth caller's address, ras_count=4.
REQ-041 RUN, ras_count=0, ret_en -> FAULT, PC frozen; same cycle halt_req+ret_en+br_taken -> HALTED, done=1, stack unchanged.
REQ-042 prog_ctr=0x005, stall 3 cycles then br_taken br_target=0x0A0 -> PC 0x005 ×3 more edges, then 0x0A0.
REQ-043 call at prog_ctr=0xFFF -> pushed 0x000; reset asserted during HALTED with ras_count=2 -> IDLE, ras_count=0, pc_reset=1.
